multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the shared-ALU, single-memory MIPS datapath. It replaces the single-cycle decoder with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux, register enable and memory strobe, and stalls on a ready handshake from the unified memory. It supports the same instruction subset as the single-cycle core: R-type, jr, jalr, addi/andi/ori/xori/slti, beq, j, jal, lw and sw.

---
 rtl/mc_ctrl_pkg.sv | 111 +++++++++++
 rtl/mc_op_decode.sv | 37 +++
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer and its opcode decoder.
package mc_ctrl_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned FN_W       = 6;
    localparam int unsigned NUM_STATES = 15;
    localparam int unsigned SEL_W      = 2;

    // One-hot sequencer states
    typedef enum logic [NUM_STATES-1:0] {
        S_FETCH  = 15'h0001,
        S_DECODE = 15'h0002,
        S_EXEC_R = 15'h0004,
        S_WB_R   = 15'h0008,
        S_EXEC_I = 15'h0010,
        S_WB_I   = 15'h0020,
        S_ADDR   = 15'h0040,
        S_MEM_RD = 15'h0080,
        S_WB_LW  = 15'h0100,
        S_MEM_WR = 15'h0200,
        S_BEQ    = 15'h0400,
        S_JUMP   = 15'h0800,
        S_JAL    = 15'h1000,
        S_JR     = 15'h2000,
        S_JALR   = 15'h4000
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_R,
        CLS_JR,
        CLS_JALR,
        CLS_ALU_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_NONE
    } instr_class_t;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // Funct codes
    localparam logic [FN_W-1:0] FN_JR   = 6'b001000;
    localparam logic [FN_W-1:0] FN_JALR = 6'b001001;
    localparam logic [FN_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
    localparam logic [FN_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
    localparam logic [FN_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FN_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [FN_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FN_W-1:0] FN_SLTU = 6'b101011;

    // Datapath mux encodings
    localparam logic [SEL_W-1:0] PCSRC_ALU     = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT  = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP    = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_REG     = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_B        = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH   = 2'b11;

    localparam logic [SEL_W-1:0] ALUOP_ADD     = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB     = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT   = 2'b10;
    localparam logic [SEL_W-1:0] ALUOP_OPCODE  = 2'b11;

    localparam logic [SEL_W-1:0] REGDST_RT     = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD     = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_RA     = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR       = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC        = 2'b10;

    // Full control word driven toward the datapath
    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             iord;
        logic             ir_write;
        logic             pc_write;
        logic             pc_write_cond;
        logic [SEL_W-1:0] pc_source;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_to_reg;
        logic             reg_write;
        logic             illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode/funct classifier, shared with the pipelined core.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [FN_W-1:0] funct,
    output instr_class_t    instr_class,
    output logic            illegal
);

    // Map the opcode (and funct for R-type) onto an instruction class
    always_comb begin
        instr_class = CLS_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_JR:   instr_class = CLS_JR;
                    FN_JALR: instr_class = CLS_JALR;
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
                    FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                             instr_class = CLS_R;
                    default: instr_class = CLS_NONE;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:
                     instr_class = CLS_ALU_I;
            OP_LW:   instr_class = CLS_LW;
            OP_SW:   instr_class = CLS_SW;
            OP_BEQ:  instr_class = CLS_BEQ;
            OP_J:    instr_class = CLS_J;
            OP_JAL:  instr_class = CLS_JAL;
            default: instr_class = CLS_NONE;
        endcase
        illegal = (instr_class == CLS_NONE);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared-ALU, single-memory MIPS datapath.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  Op,
    input  logic [FN_W-1:0]  FuncField,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [SEL_W-1:0] PCSource,
    output logic             ALUSrcA,
    output logic [SEL_W-1:0] ALUSrcB,
    output logic [SEL_W-1:0] ALUOp,
    output logic [SEL_W-1:0] RegDst,
    output logic [SEL_W-1:0] MemtoReg,
    output logic             RegWrite,
    output logic             illegal
);

    state_t       state;
    state_t       state_next;
    ctrl_t        ctl;
    instr_class_t instr_class;
    logic         dec_illegal;

    // Zero is combined with PCWriteCond in the datapath's PC-enable gate
    logic unused_zero;
    assign unused_zero = Zero;

    mc_op_decode u_dec (
        .op          (Op),
        .funct       (FuncField),
        .instr_class (instr_class),
        .illegal     (dec_illegal)
    );

    // State register, synchronous reset back to FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state and per-state control word; reset blanks every output
    always_comb begin
        state_next = state;
        ctl        = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.iord      = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed here and captured in ALUOut
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_op    = ALUOP_ADD;
                ctl.illegal   = dec_illegal;
                case (instr_class)
                    CLS_R:     state_next = S_EXEC_R;
                    CLS_JR:    state_next = S_JR;
                    CLS_JALR:  state_next = S_JALR;
                    CLS_ALU_I: state_next = S_EXEC_I;
                    CLS_LW:    state_next = S_ADDR;
                    CLS_SW:    state_next = S_ADDR;
                    CLS_BEQ:   state_next = S_BEQ;
                    CLS_J:     state_next = S_JUMP;
                    CLS_JAL:   state_next = S_JAL;
                    default:   state_next = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
                state_next    = S_WB_R;
            end
            S_WB_R: begin
                ctl.reg_dst    = REGDST_RD;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_OPCODE;
                state_next    = S_WB_I;
            end
            S_WB_I: begin
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_ALUOUT;
                ctl.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                state_next    = (instr_class == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (mem_ready) state_next = S_WB_LW;
            end
            S_WB_LW: begin
                ctl.reg_dst    = REGDST_RT;
                ctl.mem_to_reg = M2R_MDR;
                ctl.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_BEQ: begin
                ctl.alu_src_a     = 1'b1;
                ctl.alu_src_b     = SRCB_B;
                ctl.alu_op        = ALUOP_SUB;
                ctl.pc_write_cond = 1'b1;
                ctl.pc_source     = PCSRC_ALUOUT;
                state_next        = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
                state_next    = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4, so it is the link value
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_JUMP;
                ctl.reg_dst    = REGDST_RA;
                ctl.mem_to_reg = M2R_PC;
                ctl.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            S_JR: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_REG;
                state_next    = S_FETCH;
            end
            S_JALR: begin
                ctl.pc_write   = 1'b1;
                ctl.pc_source  = PCSRC_REG;
                ctl.reg_dst    = REGDST_RD;
                ctl.mem_to_reg = M2R_PC;
                ctl.reg_write  = 1'b1;
                state_next     = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
        if (!rst_n) ctl = '0;
    end

    assign MemRead     = ctl.mem_read;
    assign MemWrite    = ctl.mem_write;
    assign IorD        = ctl.iord;
    assign IRWrite     = ctl.ir_write;
    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign PCSource    = ctl.pc_source;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUOp       = ctl.alu_op;
    assign RegDst      = ctl.reg_dst;
    assign MemtoReg    = ctl.mem_to_reg;
    assign RegWrite    = ctl.reg_write;
    assign illegal     = ctl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: vector table, directed corners, random model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic [5:0] FuncField;
    logic       Zero;
    logic       mem_ready;
    logic       MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, RegDst, MemtoReg;
    logic       RegWrite, illegal;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .FuncField   (FuncField),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IorD        (IorD),
        .IRWrite     (IRWrite),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .PCSource    (PCSource),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr, mw, iord, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       srca;
        logic [1:0] srcb, aluop, regdst, m2r;
        logic       rw, ill;
    } ctl_t;

    ctl_t act;
    assign act = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSource,
                  ALUSrcA, ALUSrcB, ALUOp, RegDst, MemtoReg, RegWrite, illegal};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic check_vec(input string nm, input ctl_t a, input ctl_t e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Expected control words by phase of an instruction
    function automatic ctl_t f_fetch(input logic rdy);
        ctl_t c = '0;
        c.mr = 1'b1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy;
        return c;
    endfunction
    function automatic ctl_t f_decode(input logic ill);
        ctl_t c = '0;
        c.srcb = 2'b11; c.ill = ill;
        return c;
    endfunction
    function automatic ctl_t f_alu(input logic [1:0] srcb, input logic [1:0] aluop);
        ctl_t c = '0;
        c.srca = 1'b1; c.srcb = srcb; c.aluop = aluop;
        return c;
    endfunction
    function automatic ctl_t f_beq();
        ctl_t c = f_alu(2'b00, 2'b01);
        c.pcwc = 1'b1; c.pcsrc = 2'b01;
        return c;
    endfunction
    function automatic ctl_t f_wb(input logic [1:0] rd, input logic [1:0] m2r);
        ctl_t c = '0;
        c.rw = 1'b1; c.regdst = rd; c.m2r = m2r;
        return c;
    endfunction
    function automatic ctl_t f_mem(input logic wr);
        ctl_t c = '0;
        c.mr = ~wr; c.mw = wr; c.iord = 1'b1;
        return c;
    endfunction
    function automatic ctl_t f_jump(input logic [1:0] src, input logic link, input logic [1:0] rd);
        ctl_t c = '0;
        c.pcw = 1'b1; c.pcsrc = src;
        if (link) begin c.rw = 1'b1; c.regdst = rd; c.m2r = 2'b10; end
        return c;
    endfunction

    localparam int K_R = 0, K_JR = 1, K_JALR = 2, K_ALUI = 3, K_LW = 4, K_SW = 5,
                   K_BEQ = 6, K_J = 7, K_JAL = 8, K_ILL = 9;

    // Instruction set as listed for the core
    function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'd0: begin
                case (fn)
                    6'd8:  return K_JR;
                    6'd9:  return K_JALR;
                    6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                    6'd38, 6'd39, 6'd42, 6'd43: return K_R;
                    default: return K_ILL;
                endcase
            end
            6'd2:  return K_J;
            6'd3:  return K_JAL;
            6'd4:  return K_BEQ;
            6'd8, 6'd10, 6'd12, 6'd13, 6'd14: return K_ALUI;
            6'd35: return K_LW;
            6'd43: return K_SW;
            default: return K_ILL;
        endcase
    endfunction

    ctl_t eq[$];
    logic rq[$];

    task automatic push_any(input ctl_t c);
        eq.push_back(c); rq.push_back(1'($urandom_range(0, 1)));
    endtask
    task automatic push_mem(input ctl_t c, input int waits);
        for (int i = 0; i < waits; i++) begin eq.push_back(c); rq.push_back(1'b0); end
        eq.push_back(c); rq.push_back(1'b1);
    endtask

    // Build the per-cycle expectation and ready stream for one instruction
    task automatic plan(input int k, input int fw, input int mw);
        eq.delete(); rq.delete();
        for (int i = 0; i < fw; i++) begin eq.push_back(f_fetch(1'b0)); rq.push_back(1'b0); end
        eq.push_back(f_fetch(1'b1)); rq.push_back(1'b1);
        push_any(f_decode(1'(k == K_ILL)));
        case (k)
            K_R:    begin push_any(f_alu(2'b00, 2'b10)); push_any(f_wb(2'b01, 2'b00)); end
            K_ALUI: begin push_any(f_alu(2'b10, 2'b11)); push_any(f_wb(2'b00, 2'b00)); end
            K_LW:   begin push_any(f_alu(2'b10, 2'b00)); push_mem(f_mem(1'b0), mw);
                          push_any(f_wb(2'b00, 2'b01)); end
            K_SW:   begin push_any(f_alu(2'b10, 2'b00)); push_mem(f_mem(1'b1), mw); end
            K_BEQ:  push_any(f_beq());
            K_J:    push_any(f_jump(2'b10, 1'b0, 2'b00));
            K_JAL:  push_any(f_jump(2'b10, 1'b1, 2'b10));
            K_JR:   push_any(f_jump(2'b11, 1'b0, 2'b00));
            K_JALR: push_any(f_jump(2'b11, 1'b1, 2'b01));
            default: ;
        endcase
    endtask

    task automatic step(input logic r, input ctl_t e, input string nm);
        mem_ready = r;
        Zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_vec(nm, act, e);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        int fw, mw, cyc, rw, rd, m2r, ill, pcw, pcwc, mwc;
    } row_t;

    row_t rows[15];

    // Run one instruction from FETCH until the next FETCH, collecting a signature
    task automatic run_row(input int idx, input row_t r);
        int cyc = 0, rwc = 0, rd = 0, m2r = 0, ill = 0, pcw = 0, pcwc = 0, mwc = 0, wcnt = 0;
        logic seen = 1'b0;
        Op = r.op; FuncField = r.fn; Zero = r.zero;
        while (cyc < 40) begin
            if (seen && MemRead && !IorD) break;
            if (MemRead || MemWrite) begin
                if (wcnt < ((MemRead && !IorD) ? r.fw : r.mw)) begin
                    mem_ready = 1'b0; wcnt++;
                end else begin
                    mem_ready = 1'b1; wcnt = 0;
                end
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
            if (IRWrite) seen = 1'b1;
            if (RegWrite) begin rwc++; rd = int'(RegDst); m2r = int'(MemtoReg); end
            if (illegal) ill++;
            if (PCWrite) pcw++;
            if (PCWriteCond) pcwc++;
            if (MemWrite) mwc++;
            @(posedge clk); #1;
        end
        check($sformatf("row%0d cycles", idx), cyc, r.cyc);
        check($sformatf("row%0d regwrite", idx), rwc, r.rw);
        check($sformatf("row%0d regdst", idx), rd, r.rd);
        check($sformatf("row%0d memtoreg", idx), m2r, r.m2r);
        check($sformatf("row%0d illegal", idx), ill, r.ill);
        check($sformatf("row%0d pcwrite", idx), pcw, r.pcw);
        check($sformatf("row%0d pcwritecond", idx), pcwc, r.pcwc);
        check($sformatf("row%0d memwrite", idx), mwc, r.mwc);
    endtask

    logic [5:0] legal_ops[11];
    logic [5:0] r_fns[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //            op      fn      z     fw mw cyc rw rd m2r ill pcw pcwc mwc
        rows[0]  = '{6'd0,  6'd32, 1'b0, 0, 0, 4,  1, 1, 0,  0,  1,  0,   0};
        rows[1]  = '{6'd35, 6'd0,  1'b0, 0, 3, 8,  1, 0, 1,  0,  1,  0,   0};
        rows[2]  = '{6'd43, 6'd0,  1'b0, 1, 2, 7,  0, 0, 0,  0,  1,  0,   3};
        rows[3]  = '{6'd4,  6'd0,  1'b1, 0, 0, 3,  0, 0, 0,  0,  1,  1,   0};
        rows[4]  = '{6'd4,  6'd0,  1'b0, 0, 0, 3,  0, 0, 0,  0,  1,  1,   0};
        rows[5]  = '{6'd3,  6'd0,  1'b0, 0, 0, 3,  1, 2, 2,  0,  2,  0,   0};
        rows[6]  = '{6'd0,  6'd9,  1'b0, 0, 0, 3,  1, 1, 2,  0,  2,  0,   0};
        rows[7]  = '{6'd0,  6'd8,  1'b0, 1, 0, 4,  0, 0, 0,  0,  2,  0,   0};
        rows[8]  = '{6'd2,  6'd0,  1'b0, 0, 0, 3,  0, 0, 0,  0,  2,  0,   0};
        rows[9]  = '{6'd8,  6'd0,  1'b0, 2, 0, 6,  1, 0, 0,  0,  1,  0,   0};
        rows[10] = '{6'd63, 6'd0,  1'b0, 0, 0, 2,  0, 0, 0,  1,  1,  0,   0};
        rows[11] = '{6'd0,  6'd1,  1'b0, 0, 0, 2,  0, 0, 0,  1,  1,  0,   0};
        rows[12] = '{6'd13, 6'd0,  1'b0, 0, 1, 4,  1, 0, 0,  0,  1,  0,   0};
        rows[13] = '{6'd43, 6'd0,  1'b0, 0, 0, 4,  0, 0, 0,  0,  1,  0,   1};
        rows[14] = '{6'd35, 6'd0,  1'b0, 0, 0, 5,  1, 0, 1,  0,  1,  0,   0};

        legal_ops = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd10, 6'd12, 6'd13, 6'd14, 6'd35, 6'd43};
        r_fns     = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd8, 6'd9};

        // Reset: outputs blank while rst_n is low, even with ready high
        rst_n = 1'b0; mem_ready = 1'b1; Op = 6'd0; FuncField = 6'd0; Zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_vec($sformatf("reset%0d", i), act, '0);
            @(posedge clk);
        end
        #1;
        rst_n = 1'b1;
        step(1'b0, f_fetch(1'b0), "first_fetch_stall");

        // Table of instructions with hand-derived signatures
        for (int i = 0; i < 15; i++) run_row(i, rows[i]);

        // Random instructions against the phase-queue model
        for (int n = 0; n < 150; n++) begin
            logic [5:0] op, fn;
            int fw, mw;
            if ($urandom_range(0, 9) < 8) begin
                op = legal_ops[$urandom_range(0, 10)];
                fn = (op == 6'd0) ? r_fns[$urandom_range(0, 11)] : 6'($urandom_range(0, 63));
            end else begin
                op = 6'($urandom_range(0, 63));
                fn = 6'($urandom_range(0, 63));
            end
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 3);
            plan(kind_of(op, fn), fw, mw);
            Op = op; FuncField = fn;
            while (eq.size() > 0) begin
                logic r;
                ctl_t e;
                r = rq.pop_front();
                e = eq.pop_front();
                step(r, e, $sformatf("rand%0d op=%0d fn=%0d", n, op, fn));
            end
        end

        // Reset during the second stalled cycle of a store
        Op = 6'd43; FuncField = 6'd0;
        step(1'b1, f_fetch(1'b1), "sw_fetch");
        step(1'b1, f_decode(1'b0), "sw_decode");
        step(1'b1, f_alu(2'b10, 2'b00), "sw_addr");
        step(1'b0, f_mem(1'b1), "sw_stall1");
        mem_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("sw_reset_memwrite", int'(MemWrite), 0);
        check_vec("sw_reset_outputs", act, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, f_fetch(1'b0), "sw_after_reset");
        step(1'b1, f_fetch(1'b1), "sw_refetch");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
